// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer for one combinational eightbit_alu: fetches instructions, drives operands, writes back results.
// Optional overflow trap enabled by defining SEQ_OVF_TRAP_EN.
module alu_op_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] START_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [2:0]      alu_sel,
    input  logic [7:0]      alu_f,
    input  logic            alu_ovf,
    input  logic            alu_take_branch,
    output logic            ovf_flag,
    output logic            trap,
    output logic            done,
    input  logic [1:0]      dbg_sel,
    output logic [7:0]      dbg_data,
    output logic [1:0]      dbg_state
);

    // Fetch handshake: imem_req stays high in FETCH until a cycle with imem_ack=1;
    // that cycle transfers imem_data. Ack outside FETCH is ignored.
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [7:0]      regs [0:3];
    logic [2:0]      op_q;
    logic [1:0]      rd_q;
    logic [7:0]      imm_q;

    logic [2:0]      f_op;
    logic [1:0]      f_rd;
    logic [1:0]      f_ra;
    logic [1:0]      f_rb;
    logic            f_bimm;
    logic [7:0]      f_imm;
    logic            f_branch;
    logic            is_alu;
    logic            trap_hit;
    logic [PC_W-1:0] off_ext;

    assign f_op     = imem_data[15:13];
    assign f_rd     = imem_data[12:11];
    assign f_ra     = imem_data[10:9];
    assign f_bimm   = imem_data[8];
    assign f_imm    = imem_data[7:0];
    assign f_rb     = imem_data[7:6];
    assign f_branch = f_op[2] & f_op[1];

    assign is_alu   = ~(op_q[2] & op_q[1]);
    assign off_ext  = PC_W'($signed(imm_q));

`ifdef SEQ_OVF_TRAP_EN
    assign trap_hit = (op_q == 3'b000) && alu_ovf;
`else
    assign trap_hit = 1'b0;
`endif

    assign imem_addr = pc;
    assign dbg_data  = regs[dbg_sel];
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= START_PC;
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
            op_q     <= 3'b000;
            rd_q     <= 2'b00;
            imm_q    <= 8'h00;
            alu_a    <= 8'h00;
            alu_b    <= 8'h00;
            alu_sel  <= 3'b000;
            imem_req <= 1'b0;
            ovf_flag <= 1'b0;
            trap     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        op_q     <= f_op;
                        rd_q     <= f_rd;
                        imm_q    <= f_imm;
                        alu_sel  <= f_op;
                        alu_a    <= regs[f_ra];
                        // Branches compare R[ra] against R[rd]; operands are frozen here,
                        // so rd==ra/rb sees the pre-write value.
                        if (f_branch)    alu_b <= regs[f_rd];
                        else if (f_bimm) alu_b <= f_imm;
                        else             alu_b <= regs[f_rb];
                        imem_req <= 1'b0;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_alu) begin
                        if (trap_hit) begin
                            trap     <= 1'b1;
                            done     <= 1'b1;
                            ovf_flag <= 1'b1;
                            state    <= HALT;
                        end else begin
                            regs[rd_q] <= alu_f;
                            if (op_q == 3'b000 && alu_ovf) ovf_flag <= 1'b1;
                            pc       <= pc + PC_W'(1);
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end else if (alu_take_branch) begin
                        // A taken branch to itself is the halt idiom.
                        if (imm_q != 8'h00) begin
                            pc       <= pc + off_ext;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= HALT;
                        end
                    end else begin
                        pc       <= pc + PC_W'(1);
                        imem_req <= 1'b1;
                        state    <= FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an ALU model, an instruction memory responder
// and a queue of expected (sel, a, b) issues checked every EXEC cycle.
module tb_alu_op_sequencer;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_f;
    logic        alu_ovf;
    logic        alu_take_branch;
    logic        ovf_flag;
    logic        trap;
    logic        done;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;
    logic [1:0]  dbg_state;

    logic [15:0] imem [0:255];
    logic [18:0] exp_q[$];
    int          total;
    int          bad;
    logic        hold;
    logic        force_ack;
    int          stall;
    int          wait_cnt;

    alu_op_sequencer #(.PC_W(8), .START_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_f(alu_f), .alu_ovf(alu_ovf), .alu_take_branch(alu_take_branch),
        .ovf_flag(ovf_flag), .trap(trap), .done(done),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference eightbit_alu: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 beq, 7 bne
    always_comb begin
        alu_f           = 8'h00;
        alu_ovf         = 1'b0;
        alu_take_branch = 1'b0;
        case (alu_sel)
            3'd0: begin
                alu_f   = alu_a + alu_b;
                alu_ovf = (alu_a[7] == alu_b[7]) && (alu_f[7] != alu_a[7]);
            end
            3'd1: begin
                alu_f   = alu_a - alu_b;
                alu_ovf = (alu_a[7] != alu_b[7]) && (alu_f[7] != alu_a[7]);
            end
            3'd2: alu_f = alu_a & alu_b;
            3'd3: alu_f = alu_a | alu_b;
            3'd4: alu_f = alu_a ^ alu_b;
            3'd5: alu_f = alu_a << alu_b[2:0];
            3'd6: alu_take_branch = (alu_a == alu_b);
            default: alu_take_branch = (alu_a != alu_b);
        endcase
    end

    // Memory responder, updated shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (force_ack) begin
            imem_ack  = 1'b1;
            imem_data = imem[imem_addr];
        end else if (imem_req && !hold) begin
            if (wait_cnt < stall) begin
                wait_cnt++;
                imem_ack = 1'b0;
            end else begin
                wait_cnt  = 0;
                imem_ack  = 1'b1;
                imem_data = imem[imem_addr];
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every EXEC cycle must match the oldest expected issue.
    always @(negedge clk) begin
        if (rst_n && dbg_state == S_EXEC) begin
            if (exp_q.size() == 0) begin
                check("exec_unexpected", {13'd0, alu_sel, alu_a, alu_b}, 32'hFFFF_FFFF);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                check("exec_issue", {13'd0, alu_sel, alu_a, alu_b}, {13'd0, e});
            end
        end
    end

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] ra, input logic bimm, input logic [7:0] imm);
        return {op, rd, ra, bimm, imm};
    endfunction

    task automatic expect_issue(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        exp_q.push_back({sel, a, b});
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hC000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        hold  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Let n instructions execute, then hold the next fetch.
    task automatic step(input int n);
        int cnt;
        int cyc;
        cnt  = 0;
        cyc  = 0;
        hold = 1'b0;
        while (cnt < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (dbg_state == S_EXEC) cnt++;
        end
        check("step_timeout", cnt, n);
        hold = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reg(input logic [1:0] idx, input logic [7:0] exp);
        @(negedge clk);
        dbg_sel = idx;
        #1;
        check($sformatf("reg_r%0d", idx), dbg_data, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; start = 1'b0; dbg_sel = 2'd0;
        hold = 1'b1; force_ack = 1'b0; stall = 0; wait_cnt = 0;
        imem_ack = 1'b0; imem_data = 16'h0000;
        clear_imem();
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_state", dbg_state, S_IDLE);
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 8'h00);
        check("rst_alu", {alu_sel, alu_a, alu_b}, 19'd0);
        check("rst_flags", {ovf_flag, trap, done}, 3'b000);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) check_reg(2'(i), 8'h00);

        // Load/add and rd==ra
        clear_imem();
        imem[0] = enc(3'd3, 2'd1, 2'd0, 1'b1, 8'h05);
        imem[1] = enc(3'd3, 2'd2, 2'd0, 1'b1, 8'h03);
        imem[2] = enc(3'd0, 2'd3, 2'd1, 1'b0, {2'd2, 6'd0});
        imem[3] = enc(3'd0, 2'd1, 2'd1, 1'b0, {2'd1, 6'd0});
        expect_issue(3'd3, 8'h00, 8'h05);
        expect_issue(3'd3, 8'h00, 8'h03);
        expect_issue(3'd0, 8'h05, 8'h03);
        pulse_start();
        step(3);
        check("add_pc", imem_addr, 8'd3);
        check("add_ovf", ovf_flag, 1'b0);
        check_reg(2'd1, 8'h05);
        check_reg(2'd2, 8'h03);
        check_reg(2'd3, 8'h08);
        expect_issue(3'd0, 8'h05, 8'h05);
        step(1);
        check_reg(2'd1, 8'h0A);
        check("self_pc", imem_addr, 8'd4);
        expect_issue(3'd6, 8'h00, 8'h00);
        step(1);
        check("halt_done", done, 1'b1);
        check("halt_pc", imem_addr, 8'd4);
        hold = 1'b0;
        repeat (3) @(negedge clk);
        check("halt_req", imem_req, 1'b0);
        check("halt_held", done, 1'b1);
        pulse_start();
        check("halt_ignore_start", dbg_state, S_HALT);

        // Overflow
        do_reset();
        clear_imem();
        imem[0] = enc(3'd3, 2'd1, 2'd0, 1'b1, 8'h70);
        imem[1] = enc(3'd3, 2'd2, 2'd0, 1'b1, 8'h20);
        imem[2] = enc(3'd1, 2'd3, 2'd1, 1'b1, 8'h90);
        imem[3] = enc(3'd0, 2'd3, 2'd1, 1'b0, {2'd2, 6'd0});
        expect_issue(3'd3, 8'h00, 8'h70);
        expect_issue(3'd3, 8'h00, 8'h20);
        expect_issue(3'd1, 8'h70, 8'h90);
        pulse_start();
        step(3);
        check_reg(2'd3, 8'hE0);
        check("sub_no_ovf", ovf_flag, 1'b0);
        expect_issue(3'd0, 8'h70, 8'h20);
        step(1);
`ifdef SEQ_OVF_TRAP_EN
        check_reg(2'd3, 8'hE0);
        check("trap_set", {trap, done}, 2'b11);
        check("trap_pc", imem_addr, 8'd3);
`else
        check_reg(2'd3, 8'h90);
        check("ovf_set", ovf_flag, 1'b1);
        check("ovf_no_trap", {trap, done}, 2'b00);
        check("ovf_pc", imem_addr, 8'd4);
        expect_issue(3'd6, 8'h00, 8'h00);
        step(1);
        check("ovf_sticky", {ovf_flag, done}, 2'b11);
`endif

        // Branches with a slow memory
        do_reset();
        clear_imem();
        stall = 2;
        imem[0]  = enc(3'd3, 2'd1, 2'd0, 1'b1, 8'h07);
        imem[1]  = enc(3'd3, 2'd2, 2'd0, 1'b1, 8'h07);
        imem[2]  = enc(3'd6, 2'd0, 2'd0, 1'b0, 8'h08);
        imem[10] = enc(3'd6, 2'd2, 2'd1, 1'b0, 8'hFE);
        imem[8]  = enc(3'd7, 2'd2, 2'd1, 1'b0, 8'hFE);
        expect_issue(3'd3, 8'h00, 8'h07);
        expect_issue(3'd3, 8'h00, 8'h07);
        expect_issue(3'd6, 8'h00, 8'h00);
        pulse_start();
        step(3);
        check("br_fwd_pc", imem_addr, 8'd10);
        expect_issue(3'd6, 8'h07, 8'h07);
        step(1);
        check("beq_back_pc", imem_addr, 8'd8);
        expect_issue(3'd7, 8'h07, 8'h07);
        step(1);
        check("bne_fall_pc", imem_addr, 8'd9);
        stall = 0;

        // PC wrap in both directions
        do_reset();
        clear_imem();
        imem[0]   = enc(3'd6, 2'd0, 2'd0, 1'b0, 8'h02);
        imem[2]   = enc(3'd6, 2'd0, 2'd0, 1'b0, 8'hFC);
        imem[254] = enc(3'd3, 2'd1, 2'd0, 1'b1, 8'h01);
        imem[255] = enc(3'd3, 2'd2, 2'd0, 1'b1, 8'h02);
        repeat (2) expect_issue(3'd6, 8'h00, 8'h00);
        pulse_start();
        step(2);
        check("br_wrap_pc", imem_addr, 8'd254);
        expect_issue(3'd3, 8'h00, 8'h01);
        expect_issue(3'd3, 8'h00, 8'h02);
        step(2);
        check("inc_wrap_pc", imem_addr, 8'd0);
        check_reg(2'd2, 8'h02);

        // Ack stall, then ack asserted through EXEC
        do_reset();
        clear_imem();
        imem[0] = enc(3'd3, 2'd1, 2'd0, 1'b1, 8'h11);
        imem[1] = enc(3'd4, 2'd2, 2'd1, 1'b1, 8'hFF);
        imem[2] = enc(3'd3, 2'd3, 2'd0, 1'b1, 8'h42);
        expect_issue(3'd3, 8'h00, 8'h11);
        pulse_start();
        step(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req_addr", {imem_req, imem_addr}, {1'b1, 8'd1});
            check("stall_alu", {alu_sel, alu_a, alu_b}, {3'd3, 8'h00, 8'h11});
        end
        expect_issue(3'd4, 8'h11, 8'hFF);
        expect_issue(3'd3, 8'h00, 8'h42);
        expect_issue(3'd6, 8'h00, 8'h00);
        force_ack = 1'b1;
        step(3);
        force_ack = 1'b0;
        check_reg(2'd2, 8'hEE);
        check_reg(2'd3, 8'h42);
        check("ack_exec_halt", {done, imem_addr}, {1'b1, 8'd3});

        // Reset mid-fetch with ack present at the reset edge
        do_reset();
        clear_imem();
        imem[0] = enc(3'd3, 2'd1, 2'd0, 1'b1, 8'h5A);
        expect_issue(3'd3, 8'h00, 8'h5A);
        pulse_start();
        step(1);
        check_reg(2'd1, 8'h5A);
        check("mid_fetch_req", imem_req, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        check("mr_req", imem_req, 1'b0);
        check("mr_pc", imem_addr, 8'd0);
        check("mr_alu", {alu_sel, alu_a, alu_b}, 19'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) check_reg(2'(i), 8'h00);
        check("mr_idle_ack_ignored", {dbg_state, imem_req}, {S_IDLE, 1'b0});
        force_ack = 1'b0;

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
